// File: rtl/sim_test_monitor.sv
// End-of-test monitor: snoops data-memory stores, detects the tohost termination
// store, and reports pass/fail/timeout, exit code, counters and a window signature.
module sim_test_monitor #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h0000_1000,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter logic [ADDR_W-1:0] SIG_BASE       = 'h0000_0000,
  parameter int                SIG_BYTES      = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wmask,
  input  logic                data_wen,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [DATA_W-1:0]   exit_code,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    store_count,
  output logic [DATA_W-1:0]   signature
);

  localparam int MW = DATA_W / 8;
  localparam int XW = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;
  localparam logic [ADDR_W:0]  SIG_LO  = {1'b0, SIG_BASE};
  localparam logic [ADDR_W:0]  SIG_HI  = {1'b0, SIG_BASE} + (ADDR_W+1)'(SIG_BYTES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_exit, w_exit;
  logic [CNT_W-1:0]    r_cycle, r_store;
  logic [DATA_W-1:0]   r_sig;
  logic                w_vld, w_tohost, w_full, w_in_win, w_term;
  logic [DATA_W-1:0]   w_mask_ext, w_addr_ext;

  assign w_vld    = data_wen && (data_wmask != '0);
  assign w_full   = &data_wmask;
  assign w_tohost = (data_addr[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2]);
  // Window bounds are compared one bit wider so a window ending at the top of memory does not wrap.
  assign w_in_win = ({1'b0, data_addr} >= SIG_LO) && ({1'b0, data_addr} < SIG_HI);

  always_comb begin
    w_mask_ext = '0;
    for (int i = 0; i < MW; i++) w_mask_ext[i*8 +: 8] = {8{data_wmask[i]}};
  end

  always_comb begin
    w_addr_ext = '0;
    w_addr_ext[XW-1:0] = data_addr[XW-1:0];
  end

  always_comb begin
    w_next = r_state;
    w_exit = r_exit;
    w_term = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        if (w_vld && w_tohost) begin
          if (!w_full) begin
            w_term = 1'b1;
            w_exit = '1;
            w_next = S_FAIL;
          end else if (data_wdata[0]) begin
            w_term = 1'b1;
            w_exit = data_wdata >> 1;
            w_next = ((data_wdata >> 1) == '0) ? S_PASS : S_FAIL;
          end
        end
        if (!w_term && (r_cycle == TO_LAST)) w_next = S_TOUT;
      end
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_exit  <= '0;
      r_cycle <= '0;
      r_store <= '0;
      r_sig   <= '0;
    end else begin
      r_state <= w_next;
      r_exit  <= w_exit;
      if (r_state == S_RUN) begin
        if (r_cycle != '1) r_cycle <= r_cycle + 1'b1;
        if (w_vld && (r_store != '1)) r_store <= r_store + 1'b1;
        if (w_vld && w_in_win)
          r_sig <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ (data_wdata & w_mask_ext) ^ w_addr_ext;
      end
    end
  end

  assign done        = (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TOUT);
  assign pass        = (r_state == S_PASS);
  assign timeout     = (r_state == S_TOUT);
  assign exit_code   = r_exit;
  assign cycle_count = r_cycle;
  assign store_count = r_store;
  assign signature   = r_sig;

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
Synthesizable, parametrised end-of-test monitor. It replaces the fixed-cycle-count result check used in core benches. It snoops the core's data-memory write port and detects a tohost-style termination store to a configured address. It reports pass/fail/timeout with an exit code, cycle and store counters, and a running signature over a configurable memory window, so the same RISC-V program binaries self-check in simulation and on FPGA.

Parameters:
ADDR_W, 32, data address width
DATA_W, 32, store data width; must be a multiple of 8
CNT_W, 32, width of the cycle and store counters
TOHOST_ADDR, 32'h0000_1000, word address whose store terminates the test
TIMEOUT_CYCLES, 1000, RUN cycles allowed before TIMEOUT; must be >= 1
SIG_BASE, 32'h0000_0000, first byte address of the signature window
SIG_BYTES, 256, size of the signature window in bytes

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  level; leaves IDLE when sampled high
data_addr  in  ADDR_W  snooped store byte address
data_wdata  in  DATA_W  snooped store data
data_wmask  in  DATA_W/8  snooped byte-enable mask
data_wen  in  1  snooped write enable
done  out  1  sticky; test has ended (PASS, FAIL or TOUT)
pass  out  1  sticky; state is PASS
timeout  out  1  sticky; state is TOUT
exit_code  out  DATA_W  termination code (tohost data >> 1)
cycle_count  out  CNT_W  number of cycles spent in RUN
store_count  out  CNT_W  number of valid stores seen in RUN
signature  out  DATA_W  running checksum of stores inside the window

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE. All outputs are 0 and all counters are 0. Reset takes priority over every other event, including mid-test and in terminal states.
- A valid store is data_wen=1 and data_wmask != 0. Stores with an all-zero mask are ignored entirely.
- All outputs are registered. An event sampled at edge N is visible after edge N; there is no combinational path from inputs to outputs.
- States:
  - IDLE -> RUN when start=1. The store at the edge where start is first sampled high is ignored.
  - RUN: cycle_count increments on every RUN edge, saturating at all-ones.
    - Valid store: store_count increments, saturating at all-ones.
    - Valid store to TOHOST_ADDR (word compare; addr[1:0] ignored) with data_wmask all ones and wdata[0]=1: exit_code <= wdata >> 1. Next state is PASS if wdata >> 1 == 0, else FAIL.
    - Valid store to TOHOST_ADDR with wdata[0]=0 and a full mask: counted as an ordinary store, no termination.
    - Valid store to TOHOST_ADDR with a partial mask: protocol error -> FAIL, exit_code <= all ones.
    - No termination and cycle_count == TIMEOUT_CYCLES-1 at this edge -> TOUT, exit_code unchanged (0).
    - Termination and timeout in the same cycle: termination wins.
  - PASS, FAIL, TOUT: terminal and sticky until reset. Counters and signature freeze. start and stores are ignored.
- done = (state is PASS, FAIL or TOUT); pass = (state is PASS); timeout = (state is TOUT).
- Signature update happens in RUN only, for valid stores with SIG_BASE <= data_addr < SIG_BASE+SIG_BYTES. Comparison is unsigned and done at ADDR_W+1 bits so the window end does not wrap.
  - Update: sig <= rotl1(sig) ^ (data_wdata & expand(data_wmask)) ^ data_addr, where expand(data_wmask) replicates each mask bit over 8 data bits and data_addr is zero-extended or truncated to DATA_W.
  - A tohost store that falls inside the window also updates the signature on its terminating edge.
- cycle_count reports the cycles spent in RUN, including the terminating cycle.

Test Plan:
- Reset then start=1; at RUN cycle 5 store wdata=1 full mask to 0x1000 -> next cycle done=1, pass=1, exit_code=0, cycle_count=6, store_count=1.
- Store 0x0000_0007 full mask to 0x1000 -> FAIL; done=1, pass=0, exit_code=3.
- No tohost store with TIMEOUT_CYCLES=1000 -> after 1000 RUN cycles timeout=1, done=1, cycle_count=1000; at the same edge a tohost store wdata=1 -> PASS instead.
- Store 0x3 to 0x0 with mask 4'hF, then 0xAB to 0x4 with mask 4'h1, sig starting at 0 -> signature after 1st = 0x0000_0003; after 2nd = rotl1(0x3) ^ 0xAB ^ 0x4 = 0x0000_00A9.
- Store to 0x1000 with mask 4'h3, wdata=1 -> FAIL, exit_code=0xFFFF_FFFF; stores with wen=1 and mask=0 leave store_count unchanged.
- Assert rst_n low for one edge while in RUN with counters non-zero -> all outputs 0, state IDLE; stores before start=1 are not counted; after termination, further stores leave every output unchanged.
